seq_detect_param: RTL and testbench



---
 rtl/seq_detect_pkg.sv | 66 ++++++
 rtl/sat_counter.sv | 37 +++
 rtl/seq_detect_param.sv | 89 ++++++++
 tb/tb_seq_detect_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared elaboration-time helpers for the parametrised serial pattern detector.
// Patterns are passed as 16-bit vectors; bit (len-1) is the first bit received.
package seq_detect_pkg;

    localparam int unsigned MAX_PAT_LEN = 16;
    localparam int unsigned MAX_CNT_W   = 32;

    // Legal pattern length.
    function automatic bit pat_len_ok(input int unsigned len);
        return (len >= 2) && (len <= MAX_PAT_LEN);
    endfunction

    // Legal match counter width.
    function automatic bit cnt_w_ok(input int unsigned w);
        return (w >= 1) && (w <= MAX_CNT_W);
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of its first k bits.
    function automatic int unsigned fail_len(input logic [15:0] pattern,
                                             input int unsigned len,
                                             input int unsigned k);
        int unsigned res;
        bit          ok;
        res = 0;
        for (int unsigned l = 1; l < k; l++) begin
            ok = 1'b1;
            for (int unsigned j = 0; j < l; j++) begin
                if (pattern[4'(len - 1 - j)] != pattern[4'(len - 1 - (k - l + j))]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                res = l;
            end
        end
        return res;
    endfunction

    // Matched-prefix length after seeing bit b in state st; len means a full match.
    function automatic int unsigned next_state(input logic [15:0] pattern,
                                               input int unsigned len,
                                               input int unsigned st,
                                               input logic        b);
        int unsigned k;
        int unsigned res;
        bit          done;
        k    = st;
        res  = 0;
        done = 1'b0;
        for (int unsigned it = 0; it <= MAX_PAT_LEN; it++) begin
            if (!done) begin
                if (b == pattern[4'(len - 1 - k)]) begin
                    res  = k + 1;
                    done = 1'b1;
                end else if (k == 0) begin
                    res  = 0;
                    done = 1'b1;
                end else begin
                    k = fail_len(pattern, len, k);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Ports: CLK, RST_N (async active-low), inc (count event), clr (sync clear),
//        cnt (count, holds at all-ones), sat (high while cnt is all-ones).
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_n;

    // Clear wins over the old value, but an event on the same edge still counts.
    always_comb begin
        cnt_n = cnt;
        if (clr) begin
            cnt_n = inc ? W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt_n = cnt + W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            cnt <= cnt_n;
            sat <= (cnt_n == '1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector (KMP automaton) with saturating match count.
// Ports: CLK, RST_N (async active-low), EN (bit qualifier), I (serial bit),
//        CLR_CNT (sync counter clear), Y (registered match pulse),
//        MATCH_CNT (saturating match count), CNT_SAT (count is all-ones).
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned          PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0]   PATTERN = 5'b10011,
    parameter bit                   OVERLAP = 1'b1,
    parameter int unsigned          CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             I,
    input  logic             CLR_CNT,
    output logic             Y,
    output logic [CNT_W-1:0] MATCH_CNT,
    output logic             CNT_SAT
);

    localparam int unsigned ST_W  = $clog2(PAT_LEN);
    localparam logic [15:0] PAT16 = 16'(PATTERN);
    localparam logic [ST_W:0] LEN_C = (ST_W + 1)'(PAT_LEN);
    localparam int unsigned F_END = fail_len(PAT16, PAT_LEN, PAT_LEN);

    if (!pat_len_ok(PAT_LEN)) begin : g_bad_pat_len
        $error("seq_detect_param: PAT_LEN must be 2..16");
    end
    if (!cnt_w_ok(CNT_W)) begin : g_bad_cnt_w
        $error("seq_detect_param: CNT_W must be 1..32");
    end

    logic [ST_W-1:0]      st;
    logic [ST_W-1:0]      st_n;
    logic                 hit;
    logic [ST_W:0]        idx;
    logic [ST_W-1:0]      st_tbl [2*PAT_LEN];
    logic [2*PAT_LEN-1:0] hit_tbl;

    // Next-state / match table indexed by {st, b}, folded to constants at elaboration.
    for (genvar s = 0; s < PAT_LEN; s++) begin : g_st
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam int unsigned N  = next_state(PAT16, PAT_LEN, 32'(s), 1'(b));
            localparam int unsigned NS = (N == PAT_LEN) ? (OVERLAP ? F_END : 0) : N;
            assign st_tbl[2*s + b]  = ST_W'(NS);
            assign hit_tbl[2*s + b] = (N == PAT_LEN);
        end
    end

    assign idx = {st, I};

    // Table lookup; upset states outside 0..PAT_LEN-1 recover to empty.
    always_comb begin
        st_n = st;
        hit  = 1'b0;
        if (EN) begin
            if ({1'b0, st} < LEN_C) begin
                st_n = st_tbl[idx];
                hit  = hit_tbl[idx];
            end else begin
                st_n = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st <= '0;
            Y  <= 1'b0;
        end else begin
            st <= st_n;
            Y  <= hit;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (hit),
        .clr   (CLR_CNT),
        .cnt   (MATCH_CNT),
        .sat   (CNT_SAT)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench: five detector configurations share one stimulus stream;
// a window-based reference model predicts Y / MATCH_CNT / CNT_SAT per bit.
module tb_seq_detect_param;

    localparam int NI = 5;

    logic clk;
    logic rst_n;
    logic en;
    logic i;
    logic clr;

    logic       y_o   [NI];
    logic [7:0] cnt_o [NI];
    logic       sat_o [NI];
    logic [1:0] cnt_small;

    assign cnt_o[4] = {6'b0, cnt_small};

    typedef struct packed {
        logic [NI-1:0]      y;
        logic [NI-1:0]      sat;
        logic [NI-1:0][7:0] cnt;
    } exp_t;

    exp_t sb[$];

    int n_chk;
    int n_fail;
    int step_no;

    // Reference model configuration and state.
    int          pat  [NI];
    int          plen [NI];
    int          ovl  [NI];
    int          cmax [NI];
    logic [31:0] hist [NI];
    int          nb   [NI];
    int          mcnt [NI];

    seq_detect_param #(.PAT_LEN(5), .PATTERN(5'b10011), .OVERLAP(1'b1), .CNT_W(8)) u_d0 (
        .CLK(clk), .RST_N(rst_n), .EN(en), .I(i), .CLR_CNT(clr),
        .Y(y_o[0]), .MATCH_CNT(cnt_o[0]), .CNT_SAT(sat_o[0]));
    seq_detect_param #(.PAT_LEN(5), .PATTERN(5'b10011), .OVERLAP(1'b0), .CNT_W(8)) u_d1 (
        .CLK(clk), .RST_N(rst_n), .EN(en), .I(i), .CLR_CNT(clr),
        .Y(y_o[1]), .MATCH_CNT(cnt_o[1]), .CNT_SAT(sat_o[1]));
    seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8)) u_d2 (
        .CLK(clk), .RST_N(rst_n), .EN(en), .I(i), .CLR_CNT(clr),
        .Y(y_o[2]), .MATCH_CNT(cnt_o[2]), .CNT_SAT(sat_o[2]));
    seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b0), .CNT_W(8)) u_d3 (
        .CLK(clk), .RST_N(rst_n), .EN(en), .I(i), .CLR_CNT(clr),
        .Y(y_o[3]), .MATCH_CNT(cnt_o[3]), .CNT_SAT(sat_o[3]));
    seq_detect_param #(.PAT_LEN(5), .PATTERN(5'b10011), .OVERLAP(1'b1), .CNT_W(2)) u_d4 (
        .CLK(clk), .RST_N(rst_n), .EN(en), .I(i), .CLR_CNT(clr),
        .Y(y_o[4]), .MATCH_CNT(cnt_small), .CNT_SAT(sat_o[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            hist[k] = '0;
            nb[k]   = 0;
            mcnt[k] = 0;
        end
        sb.delete();
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input logic en_v, input logic b, input logic clr_v);
        exp_t e;
        logic match;
        @(negedge clk);
        en  = en_v;
        i   = b;
        clr = clr_v;
        e   = '0;
        for (int k = 0; k < NI; k++) begin
            match = 1'b0;
            if (en_v) begin
                hist[k] = {hist[k][30:0], b};
                nb[k]++;
                if (nb[k] >= plen[k] &&
                    (hist[k] & 32'((1 << plen[k]) - 1)) == 32'(pat[k])) begin
                    match = 1'b1;
                    if (ovl[k] == 0) nb[k] = 0;
                end
            end
            if (clr_v) mcnt[k] = match ? 1 : 0;
            else if (match && mcnt[k] < cmax[k]) mcnt[k]++;
            e.y[k]   = match;
            e.cnt[k] = 8'(mcnt[k]);
            e.sat[k] = (mcnt[k] == cmax[k]);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            for (int k = 0; k < NI; k++) begin
                check($sformatf("y[%0d]@%0d", k, step_no),   32'(y_o[k]),   32'(e.y[k]));
                check($sformatf("cnt[%0d]@%0d", k, step_no), 32'(cnt_o[k]), 32'(e.cnt[k]));
                check($sformatf("sat[%0d]@%0d", k, step_no), 32'(sat_o[k]), 32'(e.sat[k]));
            end
        end
    endtask

    task automatic run_bits(input logic [31:0] bits, input int n);
        for (int j = n - 1; j >= 0; j--) begin
            step(1'b1, bits[j], 1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s_y[%0d]", tag, k),   32'(y_o[k]),   32'd0);
            check($sformatf("%s_cnt[%0d]", tag, k), 32'(cnt_o[k]), 32'd0);
            check($sformatf("%s_sat[%0d]", tag, k), 32'(sat_o[k]), 32'd0);
        end
    endtask

    // Assert reset mid-cycle; outputs must clear before any clock edge.
    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check_zero({tag, "_async"});
        repeat (2) @(posedge clk);
        #1;
        check_zero({tag, "_held"});
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        step_no = 0;
        pat[0] = 5'b10011; plen[0] = 5; ovl[0] = 1; cmax[0] = 255;
        pat[1] = 5'b10011; plen[1] = 5; ovl[1] = 0; cmax[1] = 255;
        pat[2] = 4'b1111;  plen[2] = 4; ovl[2] = 1; cmax[2] = 255;
        pat[3] = 4'b1111;  plen[3] = 4; ovl[3] = 0; cmax[3] = 255;
        pat[4] = 5'b10011; plen[4] = 5; ovl[4] = 1; cmax[4] = 3;
        model_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        i     = 1'b0;
        clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Overlapping vs non-overlapping on 10011 stream.
        run_bits(32'b100110011, 9);
        check("t1_cnt_ovl", 32'(cnt_o[0]), 32'd2);
        check("t1_cnt_novl", 32'(cnt_o[1]), 32'd1);

        // Run of seven ones against 1111.
        pulse_reset("t3");
        run_bits(32'b1111111, 7);
        check("t3_cnt_ovl", 32'(cnt_o[2]), 32'd4);
        check("t3_cnt_novl", 32'(cnt_o[3]), 32'd1);

        // EN=0 cycles are ignored and hold state.
        pulse_reset("t4");
        run_bits(32'b10, 2);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        run_bits(32'b011, 3);
        check("t4_cnt", 32'(cnt_o[0]), 32'd1);

        // Saturation on the 2-bit counter, then clear coincident with a match.
        pulse_reset("t5");
        repeat (6) run_bits(32'b10011, 5);
        check("t5_sat_cnt", 32'(cnt_o[4]), 32'd3);
        check("t5_sat_flag", 32'(sat_o[4]), 32'd1);
        run_bits(32'b1001, 4);
        step(1'b1, 1'b1, 1'b1);
        check("t5_clr_cnt", 32'(cnt_o[4]), 32'd1);
        check("t5_clr_sat", 32'(sat_o[4]), 32'd0);

        // Reset mid-pattern discards the partial prefix.
        run_bits(32'b1001, 4);
        pulse_reset("t6");
        run_bits(32'b1, 1);
        check("t6_no_y", 32'(y_o[0]), 32'd0);
        run_bits(32'b10011, 5);
        check("t6_y", 32'(y_o[0]), 32'd1);
        check("t6_cnt", 32'(cnt_o[0]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
